// File: rtl/apb_pkg.sv
// Shared APB types and helpers for the APB memory slave.
package apb_pkg;

  typedef logic [31:0] apb_addr_t;
  typedef logic [31:0] apb_data_t;
  typedef logic [3:0]  apb_strb_t;

  localparam int unsigned APB_BYTES = 4;

  // Merge write data into an existing word, one byte lane per strobe bit.
  function automatic apb_data_t apb_strb_merge(input apb_data_t old_word,
                                               input apb_data_t wdata,
                                               input apb_strb_t strb);
    apb_data_t merged;
    merged = old_word;
    for (int k = 0; k < APB_BYTES; k++) begin
      if (strb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage with a byte-strobed write port, async read port and full export.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_idx,
  input  apb_data_t       i_wdata,
  input  apb_strb_t       i_wstrb,
  output apb_data_t       o_rdata,
  output apb_data_t       o_mem [DEPTH]
);

  apb_data_t r_mem [DEPTH];

  // Clear every word on reset, otherwise commit the strobed lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= apb_strb_merge(r_mem[i_idx], i_wdata, i_wstrb);
    end
  end

  assign o_rdata = r_mem[i_idx];
  assign o_mem   = r_mem;

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave memory: phase decode, wait-state counter, error response and
// optional read forwarding. Define APB_SLAVE_FORWARD_EN to serve reads from
// forward_i and expose the last setup address on requested_o.
// DEPTH must be a power of two and at least 2.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  apb_addr_t  paddr,
  input  apb_data_t  pwdata,
  input  apb_strb_t  pstrb,
  output apb_data_t  prdata,
  output logic       pready,
  output logic       pslverr,
  output apb_data_t  mem_o [DEPTH]
`ifdef APB_SLAVE_FORWARD_EN
  ,
  input  apb_data_t  forward_i,
  output apb_addr_t  requested_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic          w_setup;
  logic          w_access;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_wait_done;
  logic          w_err;
  logic          w_we;
  apb_data_t     w_mem_rdata;
  apb_data_t     w_rd_src;

  logic [CW-1:0] r_wait;
  apb_data_t     r_prdata;

  assign w_setup     = psel & ~penable;
  assign w_access    = psel & penable;
  assign w_idx       = paddr[AW+1:2];
  assign w_in_range  = (paddr < 32'(APB_BYTES * DEPTH));
  assign w_wait_done = (r_wait == '0);

`ifdef APB_SLAVE_FORWARD_EN
  // Forwarded reads never fault; only out-of-range writes report an error.
  assign w_err    = pwrite & ~w_in_range;
  assign w_rd_src = forward_i;
`else
  assign w_err    = ~w_in_range;
  assign w_rd_src = w_in_range ? w_mem_rdata : '0;
`endif

  assign pready  = w_access & w_wait_done;
  assign pslverr = pready & w_err;
  assign w_we    = pready & pwrite & w_in_range;
  assign prdata  = r_prdata;

  // Wait counter: load in setup, count down while the access phase stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (w_setup) begin
      r_wait <= CW'(WAIT_STATES);
    end else if (w_access && !w_wait_done) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // Read data is captured once in setup and held through the access phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prdata <= '0;
    end else if (w_setup) begin
      r_prdata <= w_rd_src;
    end
  end

`ifdef APB_SLAVE_FORWARD_EN
  apb_addr_t r_requested;

  // Remember the address of the most recent setup phase (e.g. fetch PC).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_requested <= '0;
    end else if (w_setup) begin
      r_requested <= paddr;
    end
  end

  assign requested_o = r_requested;
`endif

  apb_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (pwdata),
    .i_wstrb (pstrb),
    .o_rdata (w_mem_rdata),
    .o_mem   (mem_o)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait instance driven from a
// vector table and a two-wait instance for the multi-cycle corner cases.
module tb_apb_mem_slave;
  import apb_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int          NVEC  = 14;

  logic      clk = 1'b0;
  logic      rst;
  logic      psel0, psel2, penable, pwrite;
  apb_addr_t paddr;
  apb_data_t pwdata;
  apb_strb_t pstrb;
  apb_data_t prdata0, prdata2;
  logic      pready0, pready2, pslverr0, pslverr2;
  apb_data_t mem0 [DEPTH];
  apb_data_t mem2 [DEPTH];
`ifdef APB_SLAVE_FORWARD_EN
  apb_data_t forward_i;
  apb_addr_t req0, req2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .mem_o(mem0)
`ifdef APB_SLAVE_FORWARD_EN
    , .forward_i(forward_i), .requested_o(req0)
`endif
  );

  apb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata2),
    .pready(pready2), .pslverr(pslverr2), .mem_o(mem2)
`ifdef APB_SLAVE_FORWARD_EN
    , .forward_i(forward_i), .requested_o(req2)
`endif
  );

  typedef struct {
    logic      wr;
    apb_addr_t addr;
    apb_data_t wdata;
    apb_strb_t strb;
    apb_data_t exp_rdata;
    logic      exp_err;
    int        mem_idx;
    apb_data_t exp_mem;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic cur_pready(input bit sel2);
    return sel2 ? pready2 : pready0;
  endfunction

  function automatic logic cur_pslverr(input bit sel2);
    return sel2 ? pslverr2 : pslverr0;
  endfunction

  function automatic apb_data_t cur_prdata(input bit sel2);
    return sel2 ? prdata2 : prdata0;
  endfunction

  function automatic int nonzero_words(input bit sel2);
    int n = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((sel2 ? mem2[i] : mem0[i]) != '0) n++;
    end
    return n;
  endfunction

  // One APB transfer. Entered and left at posedge+1; the access phase stays
  // driven on return so a following call forms a back-to-back transfer.
  task automatic xfer(input bit sel2, input bit wr, input apb_addr_t a,
                      input apb_data_t d, input apb_strb_t s,
                      output apb_data_t rd, output logic err, output int waits);
    apb_data_t held;
    bit        done;
    psel0 = !sel2; psel2 = sel2; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    check("pready_in_setup", 32'(cur_pready(sel2)), 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; done = 1'b0; held = '0; rd = '0; err = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cur_pready(sel2)) begin
        rd   = cur_prdata(sel2);
        err  = cur_pslverr(sel2);
        if (waits > 0) check("prdata_stable_end", rd, held);
        done = 1'b1;
      end else begin
        check("pslverr_while_wait", 32'(cur_pslverr(sel2)), 32'd0);
        if (waits == 0) held = cur_prdata(sel2);
        else check("prdata_stable_wait", cur_prdata(sel2), held);
        waits++;
        if (waits > 16) begin
          n_cmp++; n_fail++;
          $display("FAIL pready_timeout: got no pready after %0d cycles, expected completion", waits);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    apb_data_t rd;
    logic      err;
    int        waits;

    vecs[0]  = '{1'b1, 32'h08, 32'd66408,     4'b1111, 32'h0,        1'b0, 2,  32'd66408};
    vecs[1]  = '{1'b1, 32'h0C, 32'd66408,     4'b0011, 32'h0,        1'b0, 3,  32'd872};
    vecs[2]  = '{1'b1, 32'h10, 32'd66408,     4'b0001, 32'h0,        1'b0, 4,  32'd104};
    vecs[3]  = '{1'b1, 32'h18, 32'hAAAAAAAA,  4'b1111, 32'h0,        1'b0, 6,  32'hAAAAAAAA};
    vecs[4]  = '{1'b0, 32'h18, 32'h0,         4'b0000, 32'hAAAAAAAA, 1'b0, -1, 32'h0};
    vecs[5]  = '{1'b0, 32'h28, 32'h0,         4'b0000, 32'h0,        1'b0, -1, 32'h0};
    vecs[6]  = '{1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b1, 0,  32'h0};
    vecs[7]  = '{1'b0, 32'h100, 32'h0,        4'b0000, 32'h0,        1'b1, -1, 32'h0};
    vecs[8]  = '{1'b1, 32'h14, 32'h12345678,  4'b0000, 32'h0,        1'b0, 5,  32'h0};
    vecs[9]  = '{1'b1, 32'h1F, 32'h11223344,  4'b1100, 32'h0,        1'b0, 7,  32'h11220000};
    vecs[10] = '{1'b0, 32'h1C, 32'h0,         4'b0000, 32'h11220000, 1'b0, -1, 32'h0};
    vecs[11] = '{1'b1, 32'hFC, 32'hCAFEF00D,  4'b1111, 32'h0,        1'b0, 63, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 32'hFC, 32'h0,         4'b0000, 32'hCAFEF00D, 1'b0, -1, 32'h0};
    vecs[13] = '{1'b0, 32'h08, 32'h0,         4'b0000, 32'd66408,    1'b0, -1, 32'h0};

`ifdef APB_SLAVE_FORWARD_EN
    forward_i = 32'h00000013;
    for (int i = 0; i < NVEC; i++) begin
      if (!vecs[i].wr) begin
        vecs[i].exp_rdata = 32'h00000013;
        vecs[i].exp_err   = 1'b0;
      end
    end
`endif

    rst = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_prdata",  prdata0, 32'h0);
    check("reset_pready",  32'(pready0), 32'd0);
    check("reset_pslverr", 32'(pslverr0), 32'd0);
    check("reset_mem",     32'(nonzero_words(1'b0)), 32'd0);
    @(posedge clk); #1;

    // Table-driven transfers on the zero-wait instance, issued back to back.
    for (int i = 0; i < NVEC; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_waits", i), 32'(waits), 32'd0);
      if (vecs[i].mem_idx >= 0)
        check($sformatf("v%0d_mem%0d", i, vecs[i].mem_idx), mem0[vecs[i].mem_idx], vecs[i].exp_mem);
`ifdef APB_SLAVE_FORWARD_EN
      check($sformatf("v%0d_requested", i), req0, vecs[i].addr);
`endif
    end
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

`ifdef APB_SLAVE_FORWARD_EN
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'b0000, rd, err, waits);
    check("fwd_rdata",     rd, 32'h00000013);
    check("fwd_requested", req0, 32'h40);
    check("fwd_pslverr",   32'(err), 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
`endif

    // Two wait states: write, read back, and an out-of-range write.
    xfer(1'b1, 1'b1, 32'h04, 32'h00000055, 4'b1111, rd, err, waits);
    check("ws_wr_waits", 32'(waits), 32'd2);
    check("ws_wr_err",   32'(err), 32'd0);
    check("ws_wr_mem1",  mem2[1], 32'h00000055);
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'b0000, rd, err, waits);
    check("ws_rd_waits", 32'(waits), 32'd2);
`ifdef APB_SLAVE_FORWARD_EN
    check("ws_rd_data",  rd, 32'h00000013);
`else
    check("ws_rd_data",  rd, 32'h00000055);
`endif
    xfer(1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, rd, err, waits);
    check("ws_oor_waits", 32'(waits), 32'd2);
    check("ws_oor_err",   32'(err), 32'd1);
    check("ws_oor_mem",   32'(nonzero_words(1'b1)), 32'd1);
    psel2 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Reset lands while the wait-state instance is stalled in an access phase.
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'h00000077; pstrb = 4'b1111;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("mid_pready_stall", 32'(pready2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; psel2 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_pready2",  32'(pready2), 32'd0);
    check("rst_mid_pslverr2", 32'(pslverr2), 32'd0);
    check("rst_mid_prdata2",  prdata2, 32'h0);
    check("rst_mid_mem2",     32'(nonzero_words(1'b1)), 32'd0);
    check("rst_mid_mem0",     32'(nonzero_words(1'b0)), 32'd0);
    check("rst_mid_pready0",  32'(pready0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
